sd_spi_cmd_sequencer: RTL and testbench

Sequences the SD-card SPI link on the JC header (SCK, MOSI, MISO) for the BBC micro storage path. On reset it issues the SD power-up dummy clocks. It then serialises 48-bit command frames supplied by the filing-system logic, hunts for the R1 response start bit and returns the response byte or a timeout. It sits between the card-interface registers and the physical SPI pins, and owns SCK generation and chip-select.

---
 rtl/sd_spi_cmd_sequencer_if.sv | 22 ++
 rtl/sd_spi_cmd_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sd_spi_cmd_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_spi_cmd_sequencer_if.sv
// Command/response handshake between the filing-system card registers and the SD SPI sequencer.
// The master drives command requests; the slave (sequencer) returns R1 responses.
interface sd_spi_cmd_sequencer_if;
  logic        CMD_VALID;
  logic [5:0]  CMD_INDEX;
  logic [31:0] CMD_ARG;
  logic [6:0]  CMD_CRC;
  logic        CMD_READY;
  logic        RESP_VALID;
  logic [7:0]  RESP_R1;
  logic        RESP_TIMEOUT;

  modport master (
    output CMD_VALID, CMD_INDEX, CMD_ARG, CMD_CRC,
    input  CMD_READY, RESP_VALID, RESP_R1, RESP_TIMEOUT
  );

  modport slave (
    input  CMD_VALID, CMD_INDEX, CMD_ARG, CMD_CRC,
    output CMD_READY, RESP_VALID, RESP_R1, RESP_TIMEOUT
  );
endinterface

// File: rtl/sd_spi_cmd_sequencer.sv
// SD-card SPI command sequencer: power-up clocks, 48-bit command frames,
// R1 start-bit hunt with timeout, and 8 trailing clocks with CS released.
module sd_spi_cmd_sequencer #(
  parameter int CLK_DIV      = 125,
  parameter int INIT_CLOCKS  = 80,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                       CLK,
  input  logic                       RESET,
  sd_spi_cmd_sequencer_if.slave      cmd,
  output logic                       SD_SCK,
  output logic                       SD_MOSI,
  input  logic                       SD_MISO,
  output logic                       SD_CS_N
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MAXC  = (INIT_CLOCKS > RESP_TIMEOUT)
                         ? ((INIT_CLOCKS > 48) ? INIT_CLOCKS : 48)
                         : ((RESP_TIMEOUT > 48) ? RESP_TIMEOUT : 48);
  localparam int CNT_W = $clog2(MAXC);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_TRAIL
  } state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_cnt;
  logic               sck_q, mosi_q, cs_n_q;
  logic [46:0]        frame_tail;
  logic [CNT_W-1:0]   bit_cnt;
  logic               resp_started, resp_done, timed_out;
  logic [7:0]         r1_shift;
  logic               resp_valid_q, resp_timeout_q;
  logic [7:0]         resp_r1_q;
  logic               tick, sck_rise, sck_fall;
  logic [47:0]        cmd_frame;

  assign cmd_frame = {2'b01, cmd.CMD_INDEX, cmd.CMD_ARG, cmd.CMD_CRC, 1'b1};
  assign tick      = (state != ST_IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign sck_rise  = tick && !sck_q;
  assign sck_fall  = tick && sck_q;

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_INIT;
    else       state <= state_next;
  end

  // Every phase ends on a falling SCK edge so no half-period is ever shortened.
  always_comb begin
    state_next    = state;
    cmd.CMD_READY = 1'b0;
    case (state)
      ST_INIT:
        if (sck_fall && bit_cnt == CNT_W'(INIT_CLOCKS - 1)) state_next = ST_IDLE;
      ST_IDLE: begin
        cmd.CMD_READY = 1'b1;
        if (cmd.CMD_VALID) state_next = ST_SEND;
      end
      ST_SEND:
        if (sck_fall && bit_cnt == '0) state_next = ST_WAIT_RESP;
      ST_WAIT_RESP:
        if (sck_fall && resp_done) state_next = ST_TRAIL;
      ST_TRAIL:
        if (sck_fall && bit_cnt == '0) state_next = ST_IDLE;
      default:
        state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt        <= '0;
      sck_q          <= 1'b0;
      mosi_q         <= 1'b1;
      cs_n_q         <= 1'b1;
      frame_tail     <= '1;
      bit_cnt        <= '0;
      resp_started   <= 1'b0;
      resp_done      <= 1'b0;
      timed_out      <= 1'b0;
      r1_shift       <= 8'hFF;
      resp_valid_q   <= 1'b0;
      resp_r1_q      <= 8'hFF;
      resp_timeout_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (state == ST_IDLE) begin
        div_cnt <= '0;
        sck_q   <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        sck_q   <= ~sck_q;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        ST_INIT:
          if (sck_fall)
            bit_cnt <= (bit_cnt == CNT_W'(INIT_CLOCKS - 1)) ? '0 : bit_cnt + 1'b1;
        ST_IDLE:
          if (cmd.CMD_VALID) begin
            mosi_q     <= cmd_frame[47];
            frame_tail <= cmd_frame[46:0];
            bit_cnt    <= CNT_W'(47);
            cs_n_q     <= 1'b0;
          end
        ST_SEND:
          if (sck_fall) begin
            if (bit_cnt == '0) begin
              mosi_q       <= 1'b1;
              bit_cnt      <= CNT_W'(RESP_TIMEOUT - 1);
              resp_started <= 1'b0;
              resp_done    <= 1'b0;
              timed_out    <= 1'b0;
            end else begin
              mosi_q     <= frame_tail[46];
              frame_tail <= {frame_tail[45:0], 1'b1};
              bit_cnt    <= bit_cnt - 1'b1;
            end
          end
        ST_WAIT_RESP: begin
          // While hunting, bit_cnt holds remaining polls; after the start bit it holds remaining R1 bits.
          if (sck_rise && !resp_done) begin
            if (!resp_started) begin
              if (!SD_MISO) begin
                resp_started <= 1'b1;
                r1_shift     <= {r1_shift[6:0], 1'b0};
                bit_cnt      <= CNT_W'(6);
              end else if (bit_cnt == '0) begin
                resp_done <= 1'b1;
                timed_out <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - 1'b1;
              end
            end else begin
              r1_shift <= {r1_shift[6:0], SD_MISO};
              if (bit_cnt == '0) resp_done <= 1'b1;
              else               bit_cnt   <= bit_cnt - 1'b1;
            end
          end else if (sck_fall && resp_done) begin
            cs_n_q  <= 1'b1;
            bit_cnt <= CNT_W'(7);
          end
        end
        ST_TRAIL:
          if (sck_fall) begin
            if (bit_cnt == '0) begin
              resp_valid_q   <= 1'b1;
              resp_r1_q      <= timed_out ? 8'hFF : r1_shift;
              resp_timeout_q <= timed_out;
            end else begin
              bit_cnt <= bit_cnt - 1'b1;
            end
          end
        default: ;
      endcase
    end
  end

  assign SD_SCK           = sck_q;
  assign SD_MOSI          = mosi_q;
  assign SD_CS_N          = cs_n_q;
  assign cmd.RESP_VALID   = resp_valid_q;
  assign cmd.RESP_R1      = resp_r1_q;
  assign cmd.RESP_TIMEOUT = resp_timeout_q;

endmodule

// File: tb/tb_sd_spi_cmd_sequencer.sv
// Directed bench for sd_spi_cmd_sequencer: a vector table of commands against a simple card model,
// plus hand-written sequences for power-up, back-to-back commands and mid-frame reset.
module tb_sd_spi_cmd_sequencer;
  localparam int CLK_DIV      = 2;
  localparam int INIT_CLOCKS  = 80;
  localparam int RESP_TIMEOUT = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sd_sck, sd_mosi, sd_miso, sd_cs_n;

  sd_spi_cmd_sequencer_if bus();

  sd_spi_cmd_sequencer #(
    .CLK_DIV(CLK_DIV), .INIT_CLOCKS(INIT_CLOCKS), .RESP_TIMEOUT(RESP_TIMEOUT)
  ) dut (
    .CLK(clk), .RESET(reset), .cmd(bus),
    .SD_SCK(sd_sck), .SD_MOSI(sd_mosi), .SD_MISO(sd_miso), .SD_CS_N(sd_cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cs_low_rises = 0;
  int cs_high_rises = 0;
  int mosi_zero = 0;
  int resp_pulses = 0;
  logic [47:0] mosi_frame = '0;
  int card_delay = 1000;
  logic [7:0] card_byte = 8'hFF;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [6:0]  crc;
    int          delay;
    logic [7:0]  cbyte;
    logic [47:0] exp_frame;
    logic [7:0]  exp_r1;
    logic        exp_to;
    int          exp_polls;
  } vec_t;

  vec_t vecs[5];

  // SPI monitor: first 48 CS-low rising edges form the frame, later ones are polls.
  always @(posedge sd_sck) begin
    if (!sd_cs_n) begin
      if (cs_low_rises < 48) mosi_frame = {mosi_frame[46:0], sd_mosi};
      else if (!sd_mosi) mosi_zero++;
      cs_low_rises++;
    end else begin
      cs_high_rises++;
      if (!sd_mosi) mosi_zero++;
    end
  end

  always @(negedge clk) if (bus.RESP_VALID) resp_pulses++;

  // Card model: card_delay polls of 1, then card_byte MSB-first, then 1s.
  always @* begin
    sd_miso = 1'b1;
    if (cs_low_rises >= 48 + card_delay && cs_low_rises < 56 + card_delay)
      sd_miso = card_byte[3'(55 + card_delay - cs_low_rises)];
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    cs_low_rises  = 0;
    cs_high_rises = 0;
    mosi_zero     = 0;
    resp_pulses   = 0;
    mosi_frame    = '0;
  endtask

  task automatic waitReady(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.CMD_READY) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic waitResp(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.RESP_VALID) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input logic [6:0] crc,
                               input int delay, input logic [7:0] cbyte);
    bit ok;
    waitReady(2000, ok);
    checkOutput("ready_before_cmd", 64'(ok), 64'd1);
    card_delay    = delay;
    card_byte     = cbyte;
    clearMonitor();
    bus.CMD_INDEX = idx;
    bus.CMD_ARG   = arg;
    bus.CMD_CRC   = crc;
    bus.CMD_VALID = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ready_drop_after_accept", 64'(bus.CMD_READY), 64'd0);
    checkOutput("cs_low_after_accept", 64'(sd_cs_n), 64'd0);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int n;

    vecs[0] = '{6'd0,  32'h00000000, 7'h4A, 10,   8'h01, 48'h400000000095, 8'h01, 1'b0, 18};
    vecs[1] = '{6'd55, 32'h00000000, 7'h32, 64,   8'h00, 48'h770000000065, 8'hFF, 1'b1, 64};
    vecs[2] = '{6'd41, 32'h40000000, 7'h3B, 63,   8'h05, 48'h694000000077, 8'h05, 1'b0, 71};
    vecs[3] = '{6'd17, 32'h00001000, 7'h2A, 0,    8'h00, 48'h510000100055, 8'h00, 1'b0, 8};
    vecs[4] = '{6'd8,  32'h000001AA, 7'h43, 3,    8'h7E, 48'h48000001AA87, 8'h7E, 1'b0, 11};

    bus.CMD_VALID = 1'b0;
    bus.CMD_INDEX = '0;
    bus.CMD_ARG   = '0;
    bus.CMD_CRC   = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", 64'(bus.CMD_READY), 64'd0);
    checkOutput("rst_resp_valid", 64'(bus.RESP_VALID), 64'd0);
    checkOutput("rst_resp_r1", 64'(bus.RESP_R1), 64'hFF);
    checkOutput("rst_resp_timeout", 64'(bus.RESP_TIMEOUT), 64'd0);
    checkOutput("rst_sck", 64'(sd_sck), 64'd0);
    checkOutput("rst_mosi", 64'(sd_mosi), 64'd1);
    checkOutput("rst_cs_n", 64'(sd_cs_n), 64'd1);

    reset = 1'b0;
    clearMonitor();
    waitReady(2000, ok);
    checkOutput("init_done", 64'(ok), 64'd1);
    checkOutput("init_cs_high_pulses", 64'(cs_high_rises), 64'(INIT_CLOCKS));
    checkOutput("init_cs_low_pulses", 64'(cs_low_rises), 64'd0);
    checkOutput("init_mosi_zero", 64'(mosi_zero), 64'd0);

    clearMonitor();
    repeat (40) @(negedge clk);
    checkOutput("idle_no_sck", 64'(cs_high_rises + cs_low_rises), 64'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].idx, vecs[i].arg, vecs[i].crc, vecs[i].delay, vecs[i].cbyte);
      waitResp(3000, ok);
      checkOutput($sformatf("resp_seen[%0d]", i), 64'(ok), 64'd1);
      checkOutput($sformatf("frame[%0d]", i), 64'(mosi_frame), 64'(vecs[i].exp_frame));
      checkOutput($sformatf("r1[%0d]", i), 64'(bus.RESP_R1), 64'(vecs[i].exp_r1));
      checkOutput($sformatf("timeout[%0d]", i), 64'(bus.RESP_TIMEOUT), 64'(vecs[i].exp_to));
      checkOutput($sformatf("polls[%0d]", i), 64'(cs_low_rises - 48), 64'(vecs[i].exp_polls));
      checkOutput($sformatf("trail[%0d]", i), 64'(cs_high_rises), 64'd8);
      checkOutput($sformatf("mosi_idle_high[%0d]", i), 64'(mosi_zero), 64'd0);
      checkOutput($sformatf("ready_with_resp[%0d]", i), 64'(bus.CMD_READY), 64'd1);
      @(negedge clk);
      checkOutput($sformatf("resp_pulse_len[%0d]", i), 64'(bus.RESP_VALID), 64'd0);
      checkOutput($sformatf("r1_hold[%0d]", i), 64'(bus.RESP_R1), 64'(vecs[i].exp_r1));
    end

    // Back-to-back: CMD_VALID stays high across RESP_VALID.
    waitReady(2000, ok);
    checkOutput("b2b_ready", 64'(ok), 64'd1);
    card_delay    = 2;
    card_byte     = 8'h01;
    clearMonitor();
    bus.CMD_INDEX = 6'd0;
    bus.CMD_ARG   = 32'h0;
    bus.CMD_CRC   = 7'h4A;
    bus.CMD_VALID = 1'b1;
    waitResp(3000, ok);
    checkOutput("b2b_first_resp", 64'(ok), 64'd1);
    checkOutput("b2b_first_r1", 64'(bus.RESP_R1), 64'h01);
    checkOutput("b2b_first_frame", 64'(mosi_frame), 64'h400000000095);
    card_delay    = 1;
    card_byte     = 8'h05;
    clearMonitor();
    bus.CMD_INDEX = 6'd8;
    bus.CMD_ARG   = 32'h000001AA;
    bus.CMD_CRC   = 7'h43;
    @(posedge clk);
    #1;
    checkOutput("b2b_accepted", 64'(bus.CMD_READY), 64'd0);
    checkOutput("b2b_cs_low", 64'(sd_cs_n), 64'd0);
    bus.CMD_VALID = 1'b0;
    n = 0;
    while (cs_low_rises == 0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("b2b_start_latency", 64'(n <= 2 * CLK_DIV), 64'd1);
    waitResp(3000, ok);
    checkOutput("b2b_second_resp", 64'(ok), 64'd1);
    checkOutput("b2b_second_frame", 64'(mosi_frame), 64'h48000001AA87);
    checkOutput("b2b_second_r1", 64'(bus.RESP_R1), 64'h05);

    // Reset in the middle of a frame.
    applyStimulus(6'd17, 32'h00001000, 7'h2A, 0, 8'h00);
    n = 0;
    while (cs_low_rises < 20 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrst_reached_bit20", 64'(cs_low_rises), 64'd20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_cs_n", 64'(sd_cs_n), 64'd1);
    checkOutput("midrst_sck", 64'(sd_sck), 64'd0);
    checkOutput("midrst_mosi", 64'(sd_mosi), 64'd1);
    checkOutput("midrst_ready", 64'(bus.CMD_READY), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    clearMonitor();
    waitReady(2000, ok);
    checkOutput("midrst_reinit_done", 64'(ok), 64'd1);
    checkOutput("midrst_reinit_pulses", 64'(cs_high_rises), 64'(INIT_CLOCKS));
    checkOutput("midrst_no_cs_low", 64'(cs_low_rises), 64'd0);
    checkOutput("midrst_no_resp", 64'(resp_pulses), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
